// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: register address width,
// default data width and the queued writeback entry layout.
package wb_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] data;
        logic [REG_ADDR_W-1:0]   dest;
        logic                    no_wb;
    } wb_entry_t;

    // An entry writes the register file unless it is marked no-result or targets x0.
    function automatic logic wb_writes(input logic [REG_ADDR_W-1:0] dest,
                                       input logic                  no_wb);
        return !no_wb && (dest != '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-channel writeback FIFO; full/empty come from an occupancy counter 0..DEPTH,
// so ch_ready derived from full_o is purely registered.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [XLEN-1:0]       data_i,
    input  logic [REG_ADDR_W-1:0] dest_i,
    input  logic                  no_wb_i,
    output logic [XLEN-1:0]       data_o,
    output logic [REG_ADDR_W-1:0] dest_o,
    output logic                  no_wb_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]       data_q  [DEPTH];
    logic [REG_ADDR_W-1:0] dest_q  [DEPTH];
    logic                  no_wb_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign data_o  = data_q[rd_ptr_q];
    assign dest_o  = dest_q[rd_ptr_q];
    assign no_wb_o = no_wb_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            data_q[wr_ptr_q]  <= data_i;
            dest_q[wr_ptr_q]  <= dest_i;
            no_wb_q[wr_ptr_q] <= no_wb_i;
        end
    end

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: NCH result FIFOs, one pop per cycle into registered
// register-file write outputs. Define WB_ARB_RR_EN for round-robin selection.
module wb_arb
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NCH   = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             ch_valid,
    output logic [NCH-1:0]             ch_ready,
    input  logic [NCH*XLEN-1:0]        ch_data,
    input  logic [NCH*REG_ADDR_W-1:0]  ch_dest,
    input  logic [NCH-1:0]             ch_no_wb,
    output logic                       reg_write_enable,
    output logic [XLEN-1:0]            write_data,
    output logic [REG_ADDR_W-1:0]      write_addr,
    output logic [31:0]                retire_cnt
);

    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]        full, empty, push, pop;
    logic [XLEN-1:0]       head_data  [NCH];
    logic [REG_ADDR_W-1:0] head_dest  [NCH];
    logic [NCH-1:0]        head_no_wb;

    logic                  found;
    logic [SW-1:0]         sel;

    logic                  we_q, we_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]           retire_cnt_q, retire_cnt_d;

    assign ch_ready = ~full;
    assign push     = ch_valid & ~full;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        wb_fifo #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .data_i  (ch_data[g*XLEN +: XLEN]),
            .dest_i  (ch_dest[g*REG_ADDR_W +: REG_ADDR_W]),
            .no_wb_i (ch_no_wb[g]),
            .data_o  (head_data[g]),
            .dest_o  (head_dest[g]),
            .no_wb_o (head_no_wb[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

`ifdef WB_ARB_RR_EN
    // rr_ptr_q names the channel just after the last one popped.
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!found && !empty[SW'((32'(rr_ptr_q) + k) % NCH)]) begin
                found = 1'b1;
                sel   = SW'((32'(rr_ptr_q) + k) % NCH);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (sel == SW'(NCH - 1)) ? '0 : sel + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && !empty[SW'(i)]) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
    end
`endif

    always_comb begin
        pop = '0;
        if (found) begin
            pop[sel] = 1'b1;
        end
        we_d         = found && wb_writes(head_dest[sel], head_no_wb[sel]);
        wdata_d      = we_d ? head_data[sel] : '0;
        waddr_d      = we_d ? head_dest[sel] : '0;
        retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            we_q    <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            if (found) begin
                retire_cnt_q <= retire_cnt_d;
            end
        end
    end

    assign reg_write_enable = we_q;
    assign write_data       = wdata_q;
    assign write_addr       = waddr_q;
    assign retire_cnt       = retire_cnt_q;

endmodule

// File: tb/tb_wb_arb.sv
// Scoreboard bench for wb_arb: stimulus queues expected writes, a negedge
// monitor pops them on each write strobe and checks idle cycles are zero.
module tb_wb_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ch_valid = '0;
    logic [2:0]  ch_ready;
    logic [95:0] ch_data = '0;
    logic [14:0] ch_dest = '0;
    logic [2:0]  ch_no_wb = '0;
    logic        reg_write_enable;
    logic [31:0] write_data;
    logic [4:0]  write_addr;
    logic [31:0] retire_cnt;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    wb_arb #(.XLEN(32), .NCH(3), .DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .ch_valid         (ch_valid),
        .ch_ready         (ch_ready),
        .ch_data          (ch_data),
        .ch_dest          (ch_dest),
        .ch_no_wb         (ch_no_wb),
        .reg_write_enable (reg_write_enable),
        .write_data       (write_data),
        .write_addr       (write_addr),
        .retire_cnt       (retire_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int ch, input logic [31:0] d, input logic [4:0] a, input logic nw);
        ch_valid[ch]       = 1'b1;
        ch_data[ch*32 +: 32] = d;
        ch_dest[ch*5 +: 5]   = a;
        ch_no_wb[ch]       = nw;
    endtask

    task automatic clr();
        ch_valid = '0;
        ch_data  = '0;
        ch_dest  = '0;
        ch_no_wb = '0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reg_write_enable) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%08h, expected no strobe (cycle %0d)",
                         write_addr, write_data, cyc);
            end else begin
                e = sb.pop_front();
                check("wr_addr", {27'b0, write_addr}, {27'b0, e.addr});
                check("wr_data", write_data, e.data);
                if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
            end
        end else begin
            check("idle_addr", {27'b0, write_addr}, 32'd0);
            check("idle_data", write_data, 32'd0);
        end
    end

    initial begin
        int n;

        // Reset state
        tick();
        check("rst_ready", {29'b0, ch_ready}, 32'd7);
        check("rst_we", {31'b0, reg_write_enable}, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        do_reset();

        // Single push on ch0: strobe two edges after the drive cycle
        n = cyc;
        drive(0, 32'h1234, 5'd5, 1'b0);
        expect_wr(5'd5, 32'h1234, n + 2);
        tick();
        clr();
        repeat (3) tick();
        check("s1_retire", retire_cnt, 32'd1);

        // Suppressed entries: dest=0 and no_wb=1
        do_reset();
        drive(1, 32'hFFFF, 5'd0, 1'b0);
        tick();
        clr();
        drive(2, 32'h5555, 5'd7, 1'b1);
        tick();
        clr();
        repeat (3) tick();
        check("s2_retire", retire_cnt, 32'd2);

        // Simultaneous pushes on all channels
        do_reset();
        n = cyc;
        drive(0, 32'hA0, 5'd1, 1'b0);
        drive(1, 32'hB1, 5'd2, 1'b0);
        drive(2, 32'hC2, 5'd3, 1'b0);
        expect_wr(5'd1, 32'hA0, n + 2);
        expect_wr(5'd2, 32'hB1, n + 3);
        expect_wr(5'd3, 32'hC2, n + 4);
        tick();
        clr();
        repeat (4) tick();
        check("s3_retire", retire_cnt, 32'd3);

`ifdef WB_ARB_RR_EN
        // Two entries each on ch0 and ch1: pops alternate
        do_reset();
        n = cyc;
        drive(0, 32'h100, 5'd1, 1'b0);
        drive(1, 32'h200, 5'd2, 1'b0);
        tick();
        drive(0, 32'h101, 5'd3, 1'b0);
        drive(1, 32'h201, 5'd4, 1'b0);
        expect_wr(5'd1, 32'h100, n + 2);
        expect_wr(5'd2, 32'h200, n + 3);
        expect_wr(5'd3, 32'h101, n + 4);
        expect_wr(5'd4, 32'h201, n + 5);
        tick();
        clr();
        repeat (5) tick();
        check("rr_retire", retire_cnt, 32'd4);
`else
        // ch0 streams and starves ch1, which fills to DEPTH and holds off a third push
        do_reset();
        n = cyc;
        drive(0, 32'hD0, 5'd1, 1'b0);
        drive(1, 32'hE1, 5'd2, 1'b0);
        expect_wr(5'd1, 32'hD0, n + 2);
        tick();
        check("fill_ready_1entry", {31'b0, ch_ready[1]}, 32'd1);
        drive(0, 32'hD1, 5'd3, 1'b0);
        drive(1, 32'hE2, 5'd4, 1'b0);
        expect_wr(5'd3, 32'hD1, n + 3);
        tick();
        check("fill_ready_full", {31'b0, ch_ready[1]}, 32'd0);
        check("fill_ready0", {31'b0, ch_ready[0]}, 32'd1);
        drive(0, 32'hD2, 5'd6, 1'b0);
        drive(1, 32'hE3, 5'd8, 1'b0);
        expect_wr(5'd6, 32'hD2, n + 4);
        tick();
        check("fill_ready_held", {31'b0, ch_ready[1]}, 32'd0);
        clr();
        drive(1, 32'hE3, 5'd8, 1'b0);
        tick();
        check("fill_ready_still", {31'b0, ch_ready[1]}, 32'd0);
        clr();
        expect_wr(5'd2, 32'hE1, n + 5);
        expect_wr(5'd4, 32'hE2, n + 6);
        repeat (4) tick();
        check("fill_retire", retire_cnt, 32'd5);
        check("fill_ready_drained", {29'b0, ch_ready}, 32'd7);
`endif

        // Reset with two entries queued, plus a push presented during reset
        do_reset();
        drive(0, 32'h77, 5'd10, 1'b0);
        drive(1, 32'h88, 5'd11, 1'b0);
        tick();
        clr();
        rst = 1'b1;
        drive(2, 32'h99, 5'd9, 1'b0);
        tick();
        rst = 1'b0;
        clr();
        check("midrst_ready", {29'b0, ch_ready}, 32'd7);
        check("midrst_retire", retire_cnt, 32'd0);
        repeat (4) tick();
        check("midrst_retire_after", retire_cnt, 32'd0);

        // retire_cnt wrap
        do_reset();
        tick();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.retire_cnt_q;
        drive(0, 32'hABCD, 5'd12, 1'b0);
        expect_wr(5'd12, 32'hABCD, cyc + 2);
        tick();
        clr();
        tick();
        check("retire_wrap", retire_cnt, 32'd0);
        repeat (2) tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
